// File: rtl/serial_negate_deser_if.sv
// Signal bundle between a serial negated-frame source and the deserializer.
// valid and abort are one-cycle strobes with no ready/backpressure: the sink must take word
// on the cycle valid is high (word then holds until the next valid); abort carries no data.
interface serial_negate_deser_if #(parameter int W = 8);
  logic         i;
  logic         start;
  logic         neg;
  logic [W-1:0] word;
  logic         valid;
  logic         ovf;
  logic         busy;
  logic         abort;
  logic         dbg_state;

  modport master (
    output i, start, neg,
    input  word, valid, ovf, busy, abort, dbg_state
  );

  modport slave (
    input  i, start, neg,
    output word, valid, ovf, busy, abort, dbg_state
  );
endinterface

// File: rtl/serial_negate_deser.sv
// LSB-first serial deserializer that optionally undoes two's-complement negation
// (copy bits through the first one, invert the rest) and flags most-negative frames.
module serial_negate_deser #(
  parameter int W = 8
) (
  input  logic                  t_clk,
  input  logic                  r,
  serial_negate_deser_if.slave  bus
);

  localparam int CW = $clog2(W + 1);
  localparam int SW = (W > 1) ? W - 1 : 1;
  localparam logic [W-1:0] MIN_WORD = W'(1) << (W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          seen, seen_n;
  logic          m, m_n;
  logic [SW-1:0] sr, sr_n, sr_start, sr_shift;
  logic [W-1:0]  word_q, word_n, full_word;
  logic          valid_q, valid_n;
  logic          ovf_q, ovf_n;
  logic          abort_q, abort_n;
  logic          d;

  always_comb d = bus.i ^ (seen & m);

  // Partial word fills from the top so that after W-1 bits d0 lands at sr[0].
  always_comb begin
    sr_start         = '0;
    sr_start[SW-1]   = bus.i;
    sr_shift         = sr >> 1;
    sr_shift[SW-1]   = d;
  end

  generate
    if (W > 1) begin : g_multi
      assign full_word = {d, sr};
    end else begin : g_single
      assign full_word = d;
    end
  endgenerate

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state   <= IDLE;
      cnt     <= '0;
      seen    <= 1'b0;
      m       <= 1'b0;
      sr      <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      seen    <= seen_n;
      m       <= m_n;
      sr      <= sr_n;
      word_q  <= word_n;
      valid_q <= valid_n;
      ovf_q   <= ovf_n;
      abort_q <= abort_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    seen_n  = seen;
    m_n     = m;
    sr_n    = sr;
    word_n  = word_q;
    valid_n = 1'b0;
    ovf_n   = ovf_q;
    abort_n = 1'b0;

    if (bus.start) begin
      // A start inside a frame, even on its last bit, discards that frame.
      abort_n = (state == SHIFT);
      m_n     = bus.neg;
      seen_n  = bus.i;
      cnt_n   = CW'(1);
      sr_n    = sr_start;
      if (W == 1) begin
        word_n  = W'(bus.i);
        valid_n = 1'b1;
        ovf_n   = bus.neg & (W'(bus.i) == MIN_WORD);
        state_n = IDLE;
      end else begin
        state_n = SHIFT;
      end
    end else if (state == SHIFT) begin
      seen_n = seen | bus.i;
      cnt_n  = cnt + CW'(1);
      if (cnt == CW'(W - 1)) begin
        word_n  = full_word;
        valid_n = 1'b1;
        ovf_n   = m & (full_word == MIN_WORD);
        cnt_n   = '0;
        seen_n  = 1'b0;
        state_n = IDLE;
      end else begin
        sr_n = sr_shift;
      end
    end
  end

  assign bus.word      = word_q;
  assign bus.valid     = valid_q;
  assign bus.ovf       = ovf_q;
  assign bus.abort     = abort_q;
  assign bus.busy      = (state == SHIFT);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_serial_negate_deser.sv
// Directed bench for serial_negate_deser: W=8 and W=1 instances, arithmetic reference model,
// per-cycle comparison and a queue of hand-computed decoded words.
module tb_serial_negate_deser;

  logic t_clk;
  logic r;

  serial_negate_deser_if #(.W(8)) bus8 ();
  serial_negate_deser_if #(.W(1)) bus1 ();

  serial_negate_deser #(.W(8)) dut8 (.t_clk(t_clk), .r(r), .bus(bus8));
  serial_negate_deser #(.W(1)) dut1 (.t_clk(t_clk), .r(r), .bus(bus1));

  int errors = 0;
  int checks = 0;

  // {ovf, word} of each completed W=8 frame, written by hand
  logic [8:0] exp_q[$];

  // clock / reset
  initial t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model state: bits collected so far, interpreted as numbers at frame end
  logic [7:0] m_acc;
  int         m_nb;
  bit         m_act;
  bit         m_mode;
  logic [7:0] exp_word;
  logic       exp_valid, exp_ovf, exp_abort, exp_busy;

  always @(posedge t_clk) begin
    logic [7:0] dec;
    if (r) begin
      m_acc = '0; m_nb = 0; m_act = 0; m_mode = 0;
      exp_word = '0; exp_valid = 0; exp_ovf = 0; exp_abort = 0; exp_busy = 0;
    end else begin
      exp_valid = 0;
      exp_abort = 0;
      if (bus8.start) begin
        exp_abort = m_act;
        m_act  = 1;
        m_mode = bus8.neg;
        m_acc  = '0;
        m_acc[0] = bus8.i;
        m_nb   = 1;
      end else if (m_act) begin
        m_acc[m_nb] = bus8.i;
        m_nb++;
      end
      if (m_act && m_nb == 8) begin
        dec       = m_mode ? 8'(0 - int'(m_acc)) : m_acc;
        exp_word  = dec;
        exp_valid = 1;
        exp_ovf   = m_mode && (dec == 8'h80);
        m_act     = 0;
      end
      exp_busy = m_act;
    end
    #1;
    check("word", bus8.word, exp_word);
    check("valid", bus8.valid, exp_valid);
    check("ovf", bus8.ovf, exp_ovf);
    check("abort", bus8.abort, exp_abort);
    check("busy", bus8.busy, exp_busy);
    if (bus8.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("scoreboard", {bus8.ovf, bus8.word}, e);
      end
    end
  end

  // driver tasks
  task automatic drive_bit(input logic s, input logic n, input logic b);
    @(negedge t_clk);
    bus8.start = s;
    bus8.neg   = n;
    bus8.i     = b;
  endtask

  task automatic send_bits(input logic [7:0] v, input logic n, input int nbits);
    for (int k = 0; k < nbits; k++) drive_bit(k == 0, n, v[k]);
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) drive_bit(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    r = 1'b1;
    bus8.i = 0; bus8.start = 0; bus8.neg = 0;
    bus1.i = 0; bus1.start = 0; bus1.neg = 0;
    #1;
    check("rst_word", bus8.word, 0);
    check("rst_valid", bus8.valid, 0);
    check("rst_busy", bus8.busy, 0);
    check("rst_abort", bus8.abort, 0);
    check("rst_w1_word", bus1.word, 0);
    @(negedge t_clk);
    @(negedge t_clk);
    r = 1'b0;

    exp_q.push_back({1'b0, 8'h06});
    send_bits(8'hFA, 1, 8);
    idle(2);

    exp_q.push_back({1'b1, 8'h80});
    exp_q.push_back({1'b0, 8'h00});
    send_bits(8'h80, 1, 8);
    send_bits(8'h00, 1, 8);
    idle(1);

    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b0, 8'h01});
    send_bits(8'h5A, 0, 8);
    send_bits(8'hFF, 1, 8);
    idle(2);

    // abort: restart on bit 4 of a frame
    exp_q.push_back({1'b0, 8'hFF});
    send_bits(8'h33, 1, 4);
    send_bits(8'h01, 1, 8);
    idle(2);

    // reset in the middle of bit 5
    send_bits(8'hF0, 1, 5);
    drive_bit(1'b0, 1'b1, 1'b1);
    #2;
    r = 1'b1;
    #1;
    check("midrst_word", bus8.word, 0);
    check("midrst_valid", bus8.valid, 0);
    check("midrst_ovf", bus8.ovf, 0);
    check("midrst_busy", bus8.busy, 0);
    check("midrst_abort", bus8.abort, 0);
    @(negedge t_clk);
    r = 1'b0;
    bus8.start = 0; bus8.i = 0; bus8.neg = 0;
    exp_q.push_back({1'b0, 8'h02});
    send_bits(8'hFE, 1, 8);
    idle(2);

    // W=1 instance
    @(negedge t_clk);
    bus1.start = 1; bus1.i = 1; bus1.neg = 1;
    @(posedge t_clk);
    #1;
    check("w1_valid_a", bus1.valid, 1);
    check("w1_word_a", bus1.word, 1);
    check("w1_ovf_a", bus1.ovf, 1);
    check("w1_busy_a", bus1.busy, 0);
    @(negedge t_clk);
    bus1.start = 1; bus1.i = 0; bus1.neg = 1;
    @(posedge t_clk);
    #1;
    check("w1_valid_b", bus1.valid, 1);
    check("w1_word_b", bus1.word, 0);
    check("w1_ovf_b", bus1.ovf, 0);
    check("w1_abort_b", bus1.abort, 0);
    @(negedge t_clk);
    bus1.start = 0; bus1.i = 1; bus1.neg = 0;
    @(posedge t_clk);
    #1;
    check("w1_valid_c", bus1.valid, 0);
    check("w1_word_c", bus1.word, 0);

    idle(2);
    check("scoreboard_drained", exp_q.size(), 0);
    @(negedge t_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
